uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular-buffer FIFO feeding a START/DATA/STOP
// serialiser paced by an oversampling baud tick. txd comes straight from a flop.
module uart_tx_fifo #(
   parameter int D_W    = 8,
   parameter int B_TICK = 16,
   parameter int AW     = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           baud_en,
   input  logic           wr_en,
   input  logic [D_W-1:0] wr_data,
   output logic           full,
   output logic           empty,
   output logic [AW:0]    count,
   output logic           overflow,
   output logic           txd,
   output logic           busy,
   output logic           tx_done
);
   localparam int DEPTH = 1 << AW;
   localparam int TW    = (B_TICK > 1) ? $clog2(B_TICK) : 1;
   localparam int BW    = (D_W > 1) ? $clog2(D_W) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(B_TICK - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(D_W - 1);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state_reg, state_next;
   logic [TW-1:0]  tick_cnt_reg, tick_cnt_next;
   logic [BW-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [D_W-1:0] shift_reg, shift_next;
   logic           txd_reg, txd_next;
   logic           tx_done_reg, tx_done_next;

   logic [D_W-1:0] mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]    count_reg, count_next;
   logic           full_reg, empty_reg, overflow_reg;
   logic           do_wr, do_pop, tick_end;

   assign do_wr    = wr_en && !full_reg;
   assign do_pop   = (state_reg == IDLE) && !empty_reg;
   assign tick_end = baud_en && (tick_cnt_reg == TICK_LAST);

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr_reg] <= wr_data;
   end

   always_comb begin
      count_next = count_reg;
      if (do_wr && !do_pop)
         count_next = count_reg + 1'b1;
      else if (!do_wr && do_pop)
         count_next = count_reg - 1'b1;
   end

   // Flags are registered from the next occupancy so they line up with count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         full_reg     <= 1'b0;
         empty_reg    <= 1'b1;
         overflow_reg <= 1'b0;
      end else begin
         if (do_wr)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg    <= count_next;
         full_reg     <= (count_next == DEPTH_CNT);
         empty_reg    <= (count_next == '0);
         overflow_reg <= wr_en && full_reg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         tick_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         txd_reg      <= 1'b1;
         tx_done_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tick_cnt_reg <= tick_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         txd_reg      <= txd_next;
         tx_done_reg  <= tx_done_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      tick_cnt_next = tick_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      tx_done_next  = 1'b0;
      txd_next      = 1'b1;
      case (state_reg)
         IDLE: begin
            if (!empty_reg) begin
               shift_next    = mem[rd_ptr_reg];
               tick_cnt_next = '0;
               state_next    = START;
            end
         end
         START: begin
            if (tick_end) begin
               tick_cnt_next = '0;
               bit_cnt_next  = '0;
               state_next    = DATA;
            end else if (baud_en) begin
               tick_cnt_next = tick_cnt_reg + 1'b1;
            end
         end
         DATA: begin
            if (tick_end) begin
               tick_cnt_next = '0;
               shift_next    = shift_reg >> 1;
               if (bit_cnt_reg == BIT_LAST)
                  state_next = STOP;
               else
                  bit_cnt_next = bit_cnt_reg + 1'b1;
            end else if (baud_en) begin
               tick_cnt_next = tick_cnt_reg + 1'b1;
            end
         end
         STOP: begin
            if (tick_end) begin
               tick_cnt_next = '0;
               tx_done_next  = 1'b1;
               state_next    = IDLE;
            end else if (baud_en) begin
               tick_cnt_next = tick_cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      // The line level is decided from where the FSM is heading so txd can be a flop.
      case (state_next)
         START:   txd_next = 1'b0;
         DATA:    txd_next = shift_next[0];
         default: txd_next = 1'b1;
      endcase
   end

   assign full     = full_reg;
   assign empty    = empty_reg;
   assign count    = count_reg;
   assign overflow = overflow_reg;
   assign txd      = txd_reg;
   assign busy     = (state_reg != IDLE);
   assign tx_done  = tx_done_reg;

endmodule
